// File: rtl/handshake_data_to_ctrl_pkg.sv
// Shared helpers for the elastic handshake blocks: occupancy-counter width
// and a saturating increment used by the token statistics counters.
package handshake_data_to_ctrl_pkg;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result_s;
        if (value >= max_value) begin
            result_s = max_value;
        end else begin
            result_s = value + 32'd1;
        end
        return result_s;
    endfunction

endpackage

// File: rtl/handshake_data_to_ctrl_token_slots.sv
// Payload-free token buffer: an occupancy counter with registered full/empty
// decode, so ready on one side never depends combinationally on the other.
module handshake_token_slots
    import handshake_data_to_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic accept
);

    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             emit_s;

    assign accept_s  = in_valid & in_ready_r;
    assign emit_s    = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign accept    = accept_s;

    // Next occupancy: simultaneous accept and emit leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        if (accept_s && !emit_s) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else if (!accept_s && emit_s) begin
            count_next_s = count_r - CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Occupancy register plus full/empty flags precomputed from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s != DEPTH_C);
            out_valid_r <= (count_next_s != '0);
        end
    end

endmodule

// File: rtl/handshake_data_to_ctrl.sv
// Data-to-control converter: every accepted data token becomes one buffered
// control token; the payload is only compared against a constant for debug.
module handshake_data_to_ctrl
    import handshake_data_to_ctrl_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          DEPTH        = 4,
    parameter logic [63:0] EXPECT_VALUE = 64'd0,
    parameter int          CHECK_EN     = 1,
    parameter int          SEEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic                  mismatch,
    output logic [SEEN_WIDTH-1:0] tokens_seen
);

    localparam logic [DATA_WIDTH-1:0] EXPECT_C  = DATA_WIDTH'(EXPECT_VALUE);
    localparam logic [31:0]           SEEN_MAX  = 32'hFFFF_FFFF >> (32'd32 - 32'(SEEN_WIDTH));
    localparam logic                  CHECK_ON  = (CHECK_EN != 0);

    logic                  accept_s;
    logic                  mismatch_r;
    logic [SEEN_WIDTH-1:0] tokens_seen_r;

    handshake_token_slots #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ins_valid),
        .in_ready  (ins_ready),
        .out_valid (ctrl_valid),
        .out_ready (ctrl_ready),
        .accept    (accept_s)
    );

    // Sticky debug flag: any accepted payload that differs from the constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_r <= 1'b0;
        end else if (CHECK_ON && accept_s && (ins != EXPECT_C)) begin
            mismatch_r <= 1'b1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    // Saturating count of accepted input tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            tokens_seen_r <= '0;
        end else if (accept_s) begin
            tokens_seen_r <= SEEN_WIDTH'(sat_inc(32'(tokens_seen_r), SEEN_MAX));
        end else begin
            tokens_seen_r <= tokens_seen_r;
        end
    end

    assign mismatch    = mismatch_r;
    assign tokens_seen = tokens_seen_r;

endmodule

// File: tb/tb_handshake_data_to_ctrl.sv
// Directed bench: four configurations of handshake_data_to_ctrl driven from
// one clock, outputs sampled 1 ns after the rising edge.
module tb_handshake_data_to_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: DEPTH=4, EXPECT=0x0D21, 16-bit counter
    logic        a_rst = 1'b1, a_ins_valid = 1'b0, a_ctrl_ready = 1'b0;
    logic [31:0] a_ins = 32'd0;
    logic        a_ins_ready, a_ctrl_valid, a_mismatch;
    logic [15:0] a_seen;
    // B: DEPTH=2
    logic        b_rst = 1'b1, b_ins_valid = 1'b0, b_ctrl_ready = 1'b0;
    logic        b_ins_ready, b_ctrl_valid, b_mismatch;
    logic [15:0] b_seen;
    // C: DEPTH=1
    logic        c_rst = 1'b1, c_ins_valid = 1'b0, c_ctrl_ready = 1'b0;
    logic        c_ins_ready, c_ctrl_valid, c_mismatch;
    logic [15:0] c_seen;
    // D: DEPTH=2, 4-bit counter
    logic        d_rst = 1'b1, d_ins_valid = 1'b0, d_ctrl_ready = 1'b0;
    logic        d_ins_ready, d_ctrl_valid, d_mismatch;
    logic [3:0]  d_seen;

    handshake_data_to_ctrl #(.DATA_WIDTH(32), .DEPTH(4), .EXPECT_VALUE(64'h0D21),
                             .CHECK_EN(1), .SEEN_WIDTH(16)) u_a (
        .clk(clk), .rst(a_rst), .ins(a_ins), .ins_valid(a_ins_valid),
        .ins_ready(a_ins_ready), .ctrl_valid(a_ctrl_valid), .ctrl_ready(a_ctrl_ready),
        .mismatch(a_mismatch), .tokens_seen(a_seen));

    handshake_data_to_ctrl #(.DATA_WIDTH(32), .DEPTH(2), .EXPECT_VALUE(64'd0),
                             .CHECK_EN(1), .SEEN_WIDTH(16)) u_b (
        .clk(clk), .rst(b_rst), .ins(32'd0), .ins_valid(b_ins_valid),
        .ins_ready(b_ins_ready), .ctrl_valid(b_ctrl_valid), .ctrl_ready(b_ctrl_ready),
        .mismatch(b_mismatch), .tokens_seen(b_seen));

    handshake_data_to_ctrl #(.DATA_WIDTH(32), .DEPTH(1), .EXPECT_VALUE(64'd0),
                             .CHECK_EN(1), .SEEN_WIDTH(16)) u_c (
        .clk(clk), .rst(c_rst), .ins(32'd0), .ins_valid(c_ins_valid),
        .ins_ready(c_ins_ready), .ctrl_valid(c_ctrl_valid), .ctrl_ready(c_ctrl_ready),
        .mismatch(c_mismatch), .tokens_seen(c_seen));

    handshake_data_to_ctrl #(.DATA_WIDTH(32), .DEPTH(2), .EXPECT_VALUE(64'd0),
                             .CHECK_EN(1), .SEEN_WIDTH(4)) u_d (
        .clk(clk), .rst(d_rst), .ins(32'd0), .ins_valid(d_ins_valid),
        .ins_ready(d_ins_ready), .ctrl_valid(d_ctrl_valid), .ctrl_ready(d_ctrl_ready),
        .mismatch(d_mismatch), .tokens_seen(d_seen));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int emits_b;
    int acc_b;
    int acc_c;

    initial begin
        // Reset every instance, then one idle cycle
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;
        tick();
        check_value("rst_ins_ready", 32'(a_ins_ready), 32'd1);
        check_value("rst_ctrl_valid", 32'(a_ctrl_valid), 32'd0);
        check_value("rst_mismatch", 32'(a_mismatch), 32'd0);
        check_value("rst_seen", 32'(a_seen), 32'd0);

        // Backpressure: exactly 4 accepts, no bypass, 1-cycle latency
        a_ctrl_ready = 1'b0; a_ins_valid = 1'b1; a_ins = 32'h0000_0D21;
        for (int k = 1; k <= 6; k++) begin
            check_value("fill_ins_ready", 32'(a_ins_ready), (k <= 4) ? 32'd1 : 32'd0);
            check_value("fill_ctrl_valid", 32'(a_ctrl_valid), (k >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        check_value("fill_seen", 32'(a_seen), 32'd4);
        check_value("fill_mismatch", 32'(a_mismatch), 32'd0);

        // Drain: 4 emits, then empty
        a_ins_valid = 1'b0; a_ctrl_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check_value("drain_ctrl_valid", 32'(a_ctrl_valid), (k <= 4) ? 32'd1 : 32'd0);
            tick();
        end
        check_value("drain_ins_ready", 32'(a_ins_ready), 32'd1);

        // Refill to full, then reset while input still offered
        a_ctrl_ready = 1'b0; a_ins_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check_value("full_ins_ready", 32'(a_ins_ready), 32'd0);
        check_value("full_seen", 32'(a_seen), 32'd8);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0; a_ins_valid = 1'b0;
        check_value("midrst_ctrl_valid", 32'(a_ctrl_valid), 32'd0);
        check_value("midrst_ins_ready", 32'(a_ins_ready), 32'd1);
        check_value("midrst_seen", 32'(a_seen), 32'd0);
        tick();
        check_value("midrst_ctrl_valid2", 32'(a_ctrl_valid), 32'd0);
        check_value("midrst_seen2", 32'(a_seen), 32'd0);

        // Mismatch: 0x0D21, 0x0D21, 0x0001, then 20 matching tokens
        a_ctrl_ready = 1'b1; a_ins_valid = 1'b1; a_ins = 32'h0000_0D21;
        tick(); tick();
        check_value("mm_before", 32'(a_mismatch), 32'd0);
        a_ins = 32'h0000_0001;
        tick();
        check_value("mm_set", 32'(a_mismatch), 32'd1);
        a_ins = 32'h0000_0D21;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_value("mm_sticky", 32'(a_mismatch), 32'd1);
        end
        check_value("mm_seen", 32'(a_seen), 32'd23);
        a_ins_valid = 1'b0; a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check_value("mm_cleared", 32'(a_mismatch), 32'd0);

        // Throughput: DEPTH=2 and DEPTH=1 with both sides held ready
        emits_b = 0; acc_b = 0; acc_c = 0;
        b_ins_valid = 1'b1; b_ctrl_ready = 1'b1;
        c_ins_valid = 1'b1; c_ctrl_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (b_ctrl_valid) emits_b = emits_b + 1;
            if (b_ins_ready)  acc_b = acc_b + 1;
            if (c_ins_ready)  acc_c = acc_c + 1;
            tick();
        end
        b_ins_valid = 1'b0; c_ins_valid = 1'b0;
        check_value("d2_emits", 32'(emits_b), 32'd99);
        check_value("d2_accepts", 32'(acc_b), 32'd100);
        check_value("d2_seen", 32'(b_seen), 32'd100);
        check_value("d2_ctrl_valid", 32'(b_ctrl_valid), 32'd1);
        check_value("d1_accepts", 32'(acc_c), 32'd50);
        check_value("d1_seen", 32'(c_seen), 32'd50);

        // Saturation of a 4-bit counter
        d_ins_valid = 1'b1; d_ctrl_ready = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        check_value("sat_14", 32'(d_seen), 32'd14);
        tick();
        check_value("sat_15", 32'(d_seen), 32'd15);
        for (int k = 0; k < 5; k++) tick();
        check_value("sat_hold", 32'(d_seen), 32'd15);
        d_ins_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_data_to_ctrl.md
# handshake_data_to_ctrl

Elastic converter from a data channel to a dataless control channel, the reverse of the constant source that turns a control token into a data token. Each accepted data token is buffered as one control token and reissued on the control output. The data payload is dropped after an optional comparison against an expected constant, which drives a sticky mismatch flag for debug. It sits where a dataflow graph needs only the arrival event of a value, for example to sequence a later constant or a join, and it breaks the ready path between the two sides.

## Interface
- DATA_WIDTH, 32, width of the incoming data payload.
- DEPTH, 4, number of control-token slots, legal range 1..255.
- EXPECT_VALUE, 0, constant that every payload is compared against, zero-extended or truncated to DATA_WIDTH.
- CHECK_EN, 1, enables the comparison; when 0, mismatch is tied to 0.
- SEEN_WIDTH, 16, width of the saturating accepted-token counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ins  in  DATA_WIDTH  data payload of the input channel.
- ins_valid  in  1  input token offered.
- ins_ready  out  1  block can accept a token.
- ctrl_valid  out  1  control token available.
- ctrl_ready  in  1  downstream accepts the control token.
- mismatch  out  1  sticky flag, set when an accepted payload differs from EXPECT_VALUE.
- tokens_seen  out  SEEN_WIDTH  count of accepted input tokens, saturating.

## Operation
- State is held in `count`, the number of buffered control tokens, ranging 0..DEPTH and $clog2(DEPTH+1) bits wide. No payload storage is required.
- ins_ready = (count != DEPTH). ctrl_valid = (count != 0). Both are decoded from registers only, so there is no combinational path from ctrl_ready to ins_ready or from ins_valid to ctrl_valid.
- A token is accepted when ins_valid & ins_ready. A token is emitted when ctrl_valid & ctrl_ready.
- count_next = count + accept − emit. When accept and emit occur in the same cycle, count is unchanged.
- On full (count == DEPTH), ins_ready is 0 even when ctrl_ready is 1 in that cycle. The freed slot is visible the next cycle.
- On empty (count == 0), ctrl_valid is 0. A token accepted in this cycle is emitted no earlier than the next cycle. There is no bypass.
- Mismatch: on an accept with CHECK_EN=1 and ins != EXPECT_VALUE[DATA_WIDTH-1:0], mismatch is set in the following cycle. It is cleared only by rst.
- tokens_seen increments on every accept and holds at 2^SEEN_WIDTH−1.
- The input follows the valid/ready protocol: the upstream must hold ins and ins_valid until accepted. The block does not check this.

## Timing
- Reset values: count=0, ins_ready=1 (DEPTH≥1), ctrl_valid=0, mismatch=0, tokens_seen=0.
- A reset asserted mid-operation discards all buffered tokens at the next edge. Tokens offered or emitted in the reset cycle are not counted.
- Latency is one cycle from accept to ctrl_valid.
- Throughput:
  - DEPTH ≥ 2: one token per cycle sustained when ctrl_ready stays high.
  - DEPTH = 1: one token every 2 cycles, by design.
- Backpressure: with ctrl_ready low, the block accepts exactly DEPTH tokens, then ins_ready drops the cycle after the last accept.

## Structure
- A shared handshake package holds the count-width helper function (clog2 of DEPTH+1) and a saturating-increment function, both reused by the other elastic blocks.
- One sub-module, handshake_token_slots, holds the count register, the full and empty decode, and the accept/emit update. The top level adds the payload comparator, the mismatch flag and tokens_seen.

## Test plan
- Reset with DEPTH=4, then 1 idle cycle: ins_ready=1, ctrl_valid=0, mismatch=0, tokens_seen=0.
- ctrl_ready held 0, ins_valid held 1 with ins=0: 4 accepts, ins_ready=0 from cycle 5, tokens_seen=4. Then ctrl_ready=1 for 4 cycles: 4 emits, and ctrl_valid=0 afterwards.
- DEPTH=2, ins_valid and ctrl_ready both held 1 for 100 cycles: 99 emits, count stays at 1, no stall after the first cycle. Repeat with DEPTH=1: 50 accepts.
- EXPECT_VALUE=0x0D21, send 0x0D21, 0x0D21, 0x0001: mismatch rises exactly one cycle after the third accept and stays 1 through 20 further matching tokens until rst.
- Full buffer (count=4) with rst pulsed for 1 cycle while ins_valid=1: next cycle count=0, ctrl_valid=0, tokens_seen=0, and no token accepted in the reset cycle.
- SEEN_WIDTH=4, 20 accepts: tokens_seen reads 15 and holds there.
